// File: rtl/ipml_reg_fifo_v2_0_if.sv
// Handshake bundle for the register FWFT FIFO: producer/consumer side signals plus status.
interface ipml_reg_fifo_v2_0_if #(
   parameter int W     = 8,
   parameter int DEPTH = 2
);
   localparam int LW = $clog2(DEPTH + 1);

   logic          flush;
   logic          data_in_valid;
   logic [W-1:0]  data_in;
   logic          data_in_ready;
   logic          data_out_ready;
   logic [W-1:0]  data_out;
   logic          data_out_valid;
   logic [LW-1:0] level;
   logic          almost_full;
   logic          almost_empty;
   logic          overflow;
   logic          underflow;

   modport master (
      output flush, data_in_valid, data_in, data_out_ready,
      input  data_in_ready, data_out, data_out_valid, level,
             almost_full, almost_empty, overflow, underflow
   );

   modport slave (
      input  flush, data_in_valid, data_in, data_out_ready,
      output data_in_ready, data_out, data_out_valid, level,
             almost_full, almost_empty, overflow, underflow
   );
endinterface

// File: rtl/ipml_reg_fifo_v2_0.sv
// Register-array first-word-fall-through FIFO with valid/ready on both sides,
// fill level, almost flags, synchronous flush and sticky over/underflow flags.
module ipml_reg_fifo_v2_0 #(
   parameter int W             = 8,
   parameter int DEPTH         = 2,
   parameter int c_FULL_BYPASS = 0,
   parameter int c_AF_LEVEL    = DEPTH - 1,
   parameter int c_AE_LEVEL    = 1
) (
   input logic                clk,
   input logic                rst_n,
   ipml_reg_fifo_v2_0_if.slave fifo_if
);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   localparam logic [LW-1:0] c_DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] c_AF_L    = LW'(c_AF_LEVEL);
   localparam logic [LW-1:0] c_AE_L    = LW'(c_AE_LEVEL);
   localparam logic [PW-1:0] c_LAST    = PW'(DEPTH - 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wrPtr;
   logic [PW-1:0] r_rdPtr;
   logic [LW-1:0] r_level;
   logic          r_readyEn;
   logic          r_overflow;
   logic          r_underflow;

   logic          w_full;
   logic          w_empty;
   logic          w_inReady;
   logic          w_outValid;
   logic          w_push;
   logic          w_pop;

   assign w_full     = (r_level == c_DEPTH_L);
   assign w_empty    = (r_level == '0);
   assign w_outValid = ~w_empty;

   // Bypass variant lets a full FIFO accept when the head is leaving this cycle.
   generate
      if (c_FULL_BYPASS != 0) begin : g_bypass
         assign w_inReady = r_readyEn & (~w_full | fifo_if.data_out_ready);
      end else begin : g_noBypass
         assign w_inReady = r_readyEn & ~w_full;
      end
   endgenerate

   assign w_push = fifo_if.data_in_valid & w_inReady & ~fifo_if.flush;
   assign w_pop  = w_outValid & fifo_if.data_out_ready & ~fifo_if.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_push) begin
         r_mem[r_wrPtr] <= fifo_if.data_in;
      end
   end

   // r_readyEn keeps data_in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wrPtr     <= '0;
         r_rdPtr     <= '0;
         r_level     <= '0;
         r_readyEn   <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_readyEn <= 1'b1;
         if (fifo_if.flush) begin
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
         end else begin
            if (w_push) begin
               r_wrPtr <= (r_wrPtr == c_LAST) ? '0 : r_wrPtr + PW'(1);
            end
            if (w_pop) begin
               r_rdPtr <= (r_rdPtr == c_LAST) ? '0 : r_rdPtr + PW'(1);
            end
            case ({w_push, w_pop})
               2'b10:   r_level <= r_level + LW'(1);
               2'b01:   r_level <= r_level - LW'(1);
               default: r_level <= r_level;
            endcase
            if (fifo_if.data_in_valid && !w_inReady) begin
               r_overflow <= 1'b1;
            end
            if (fifo_if.data_out_ready && !w_outValid) begin
               r_underflow <= 1'b1;
            end
         end
      end
   end

   assign fifo_if.data_in_ready  = w_inReady;
   assign fifo_if.data_out       = r_mem[r_rdPtr];
   assign fifo_if.data_out_valid = w_outValid;
   assign fifo_if.level          = r_level;
   assign fifo_if.almost_full    = (r_level >= c_AF_L);
   assign fifo_if.almost_empty   = (r_level <= c_AE_L);
   assign fifo_if.overflow       = r_overflow;
   assign fifo_if.underflow      = r_underflow;
endmodule

// File: tb/tb_ipml_reg_fifo_v2_0.sv
// Scoreboard bench: two DEPTH=4 FIFOs (registered-ready and bypass-ready) sharing clock and reset.
module tb_ipml_reg_fifo_v2_0;
   logic clk;
   logic rst_n;

   int checks;
   int errors;

   logic [7:0] expQ0[$];
   logic [7:0] expQ1[$];

   ipml_reg_fifo_v2_0_if #(.W(8), .DEPTH(4)) a ();
   ipml_reg_fifo_v2_0_if #(.W(8), .DEPTH(4)) b ();

   ipml_reg_fifo_v2_0 #(.W(8), .DEPTH(4), .c_FULL_BYPASS(0)) dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo_if (a)
   );

   ipml_reg_fifo_v2_0 #(.W(8), .DEPTH(4), .c_FULL_BYPASS(1)) dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .fifo_if (b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Head word leaves at the next edge whenever valid&ready is seen mid-cycle.
   always @(negedge clk) begin
      if (rst_n && !a.flush && a.data_out_valid && a.data_out_ready) begin
         if (expQ0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb0Unexpected: got %0h, expected no word", a.data_out);
         end else begin
            checkOutput("sb0Data", a.data_out, expQ0.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && !b.flush && b.data_out_valid && b.data_out_ready) begin
         if (expQ1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb1Unexpected: got %0h, expected no word", b.data_out);
         end else begin
            checkOutput("sb1Data", b.data_out, expQ1.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pushes one word into dut0, waiting (bounded) for data_in_ready.
   task automatic applyStimulus(input logic [7:0] d);
      int n;
      n = 0;
      a.data_in       = d;
      a.data_in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (a.data_in_ready) begin
            expQ0.push_back(d);
            break;
         end
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL pushTimeout: data_in_ready stayed 0, expected 1");
            break;
         end
         step();
      end
      step();
      a.data_in_valid = 1'b0;
   endtask

   task automatic drain0();
      int n;
      n = 0;
      if (a.level != 0) begin
         a.data_out_ready = 1'b1;
         forever begin
            @(negedge clk);
            if (a.level == 1) break;
            n++;
            if (n > 50) begin
               checks++;
               errors++;
               $display("[TB] FAIL drainTimeout: level=%0d, expected 1", a.level);
               break;
            end
            step();
         end
         step();
         a.data_out_ready = 1'b0;
      end
      checkOutput("sb0Drained", expQ0.size(), 0);
   endtask

   task automatic flush0();
      a.flush = 1'b1;
      step();
      a.flush = 1'b0;
      expQ0.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] d;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      a.flush = 1'b0; a.data_in_valid = 1'b0; a.data_in = '0; a.data_out_ready = 1'b0;
      b.flush = 1'b0; b.data_in_valid = 1'b0; b.data_in = '0; b.data_out_ready = 1'b0;

      // T1: reset and idle
      #23;
      checkOutput("rstInReady", a.data_in_ready, 0);
      checkOutput("rstLevel", a.level, 0);
      #4 rst_n = 1'b1;
      step();
      @(negedge clk);
      checkOutput("idleInReady", a.data_in_ready, 1);
      checkOutput("idleOutValid", a.data_out_valid, 0);
      checkOutput("idleLevel", a.level, 0);
      checkOutput("idleAlmostEmpty", a.almost_empty, 1);
      checkOutput("idleAlmostFull", a.almost_full, 0);
      checkOutput("idleDataOut", a.data_out, 0);
      step();

      // T2: fill to full, then drain in order
      applyStimulus(8'h11);
      applyStimulus(8'h22);
      applyStimulus(8'h33);
      applyStimulus(8'h44);
      @(negedge clk);
      checkOutput("fullLevel", a.level, 4);
      checkOutput("fullInReady", a.data_in_ready, 0);
      checkOutput("fullAlmostFull", a.almost_full, 1);
      checkOutput("fullAlmostEmpty", a.almost_empty, 0);
      checkOutput("fullHead", a.data_out, 8'h11);
      step();
      drain0();
      @(negedge clk);
      checkOutput("drainLevel", a.level, 0);
      checkOutput("drainUnderflow", a.underflow, 0);
      step();

      // Underflow: ready on an empty FIFO is sticky until flush
      a.data_out_ready = 1'b1;
      step();
      a.data_out_ready = 1'b0;
      step();
      @(negedge clk);
      checkOutput("underflowSet", a.underflow, 1);
      step();
      flush0();
      @(negedge clk);
      checkOutput("underflowClr", a.underflow, 0);
      step();

      // T3: wrap the pointers with push 3 / pop 3 rounds
      d = 8'h30;
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) begin
            applyStimulus(d);
            d = d + 8'h01;
         end
         @(negedge clk);
         checkOutput("wrapLevel", a.level, 3);
         step();
         drain0();
      end

      // T4 (registered ready): valid at full sets overflow
      applyStimulus(8'h61);
      applyStimulus(8'h62);
      applyStimulus(8'h63);
      applyStimulus(8'h64);
      a.data_in = 8'h99;
      a.data_in_valid = 1'b1;
      a.data_out_ready = 1'b0;
      @(negedge clk);
      checkOutput("noBypInReady", a.data_in_ready, 0);
      step();
      a.data_in_valid = 1'b0;
      @(negedge clk);
      checkOutput("overflowSet", a.overflow, 1);
      checkOutput("overflowLevel", a.level, 4);
      step();
      drain0();
      flush0();
      @(negedge clk);
      checkOutput("overflowClr", a.overflow, 0);
      step();

      // T4 (bypass ready): full FIFO streams one word per cycle
      b.data_out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         b.data_in = 8'h50 + 8'(i);
         b.data_in_valid = 1'b1;
         @(negedge clk);
         checkOutput("bypFillReady", b.data_in_ready, 1);
         if (b.data_in_ready) expQ1.push_back(b.data_in);
         step();
      end
      b.data_out_ready = 1'b1;
      for (int i = 4; i < 12; i++) begin
         b.data_in = 8'h50 + 8'(i);
         @(negedge clk);
         checkOutput("bypInReady", b.data_in_ready, 1);
         checkOutput("bypLevel", b.level, 4);
         if (b.data_in_ready) expQ1.push_back(b.data_in);
         step();
      end
      b.data_in_valid = 1'b0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (b.level <= 1) break;
         step();
      end
      step();
      b.data_out_ready = 1'b0;
      checkOutput("sb1Drained", expQ1.size(), 0);
      checkOutput("bypOverflow", b.overflow, 0);

      // T5: flush at level 3 with a coincident push
      applyStimulus(8'h01);
      applyStimulus(8'h02);
      applyStimulus(8'h03);
      a.flush = 1'b1;
      a.data_in = 8'h77;
      a.data_in_valid = 1'b1;
      step();
      a.flush = 1'b0;
      a.data_in_valid = 1'b0;
      expQ0.delete();
      @(negedge clk);
      checkOutput("flushLevel", a.level, 0);
      checkOutput("flushOutValid", a.data_out_valid, 0);
      checkOutput("flushOverflow", a.overflow, 0);
      step();
      applyStimulus(8'hA5);
      @(negedge clk);
      checkOutput("postFlushValid", a.data_out_valid, 1);
      checkOutput("postFlushData", a.data_out, 8'hA5);
      checkOutput("postFlushLevel", a.level, 1);
      step();
      drain0();

      // T6: asynchronous reset mid-stream
      applyStimulus(8'hC1);
      applyStimulus(8'hC2);
      a.data_in = 8'h66;
      a.data_in_valid = 1'b1;
      a.data_out_ready = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("asyncLevel", a.level, 0);
      checkOutput("asyncOutValid", a.data_out_valid, 0);
      checkOutput("asyncInReady", a.data_in_ready, 0);
      expQ0.delete();
      a.data_in_valid = 1'b0;
      a.data_out_ready = 1'b0;
      step();
      step();
      #3 rst_n = 1'b1;
      step();
      @(negedge clk);
      checkOutput("reRstInReady", a.data_in_ready, 1);
      checkOutput("reRstLevel", a.level, 0);
      checkOutput("reRstDataOut", a.data_out, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
